// File: rtl/dispenser_pkg.sv
// dispenser_pkg: shared states, denominations and error codes for the cash dispenser
package dispenser_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_CHECK, S_DISPENSE, S_GAP, S_DONE, S_FAIL
  } state_t;
  localparam int NUM_CASSETTES = 4;
  localparam logic [31:0] DENOM [0:NUM_CASSETTES-1] = '{32'd20000, 32'd10000, 32'd5000, 32'd1000};
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COMPOSE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/dispenser_watchdog.sv
// dispenser_watchdog: counts cycles while enabled and flags expiry on the TIMEOUT-th cycle
module dispenser_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= en ? cnt + 1'b1 : '0;
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/cash_dispenser_sequencer.sv
// cash_dispenser_sequencer: greedy bill planning over four cassettes and STB/ACK feeder sequencing.
// DISPENSER_TIMEOUT_EN adds an ACK watchdog that aborts with ERR_TIMEOUT.
module cash_dispenser_sequencer
  import dispenser_pkg::*;
#(
  parameter int MONTO_W       = 32,
  parameter int CNT_W         = 8,
  parameter int CASSETTE_FULL = 50,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENTREGAR_DINERO,
  input  logic [MONTO_W-1:0] MONTO,
  input  logic               RECARGA,
  input  logic               BILLETE_ACK,
  output logic               BILLETE_STB,
  output logic [1:0]         BILLETE_SEL,
  output logic               OCUPADO,
  output logic               ENTREGA_OK,
  output logic               ENTREGA_ERROR,
  output logic [1:0]         ERROR_CODE,
  output logic [MONTO_W-1:0] RESTANTE
);
  state_t             state;
  logic [MONTO_W-1:0] rem;
  logic [1:0]         idx;
  logic [CNT_W-1:0]   plan  [NUM_CASSETTES];
  logic [CNT_W-1:0]   count [NUM_CASSETTES];
  logic [MONTO_W-1:0] denom_i;
  logic               plan_empty;
  logic               expired;

  assign denom_i       = MONTO_W'(DENOM[idx]);
  assign plan_empty    = plan[0] == '0 && plan[1] == '0 && plan[2] == '0 && plan[3] == '0;
  assign BILLETE_STB   = state == S_DISPENSE && plan[idx] != '0;
  assign BILLETE_SEL   = idx;
  assign OCUPADO       = state inside {S_PLAN, S_CHECK, S_DISPENSE, S_GAP};
  assign ENTREGA_OK    = state == S_DONE;
  assign ENTREGA_ERROR = state == S_FAIL;

`ifdef DISPENSER_TIMEOUT_EN
  dispenser_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_watchdog (
    .clk(CLK), .rst_n(RESET), .en(BILLETE_STB), .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ACK_TIMEOUT != 0;
  assign expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state      <= S_IDLE;
      rem        <= '0;
      idx        <= '0;
      RESTANTE   <= '0;
      ERROR_CODE <= ERR_NONE;
      for (int k = 0; k < NUM_CASSETTES; k++) begin
        plan[k]  <= '0;
        count[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (RECARGA)
            for (int k = 0; k < NUM_CASSETTES; k++) count[k] <= CNT_W'(CASSETTE_FULL);
          if (ENTREGAR_DINERO) begin
            rem        <= MONTO;
            RESTANTE   <= MONTO;
            ERROR_CODE <= ERR_NONE;
            idx        <= '0;
            for (int k = 0; k < NUM_CASSETTES; k++) plan[k] <= '0;
            state      <= S_PLAN;
          end
        end
        S_PLAN:
          if (rem >= denom_i && plan[idx] < count[idx]) begin
            plan[idx] <= plan[idx] + 1'b1;
            rem       <= rem - denom_i;
          end else begin
            idx <= idx + 1'b1;
            if (idx == 2'd3) state <= S_CHECK;
          end
        S_CHECK:
          if (rem != '0) begin
            ERROR_CODE <= ERR_COMPOSE;
            state      <= S_FAIL;
          end else begin
            rem   <= RESTANTE;
            idx   <= '0;
            state <= S_DISPENSE;
          end
        S_DISPENSE:
          if (plan_empty) state <= S_DONE;
          else if (plan[idx] == '0) idx <= idx + 1'b1;
          else if (BILLETE_ACK) begin
            plan[idx]  <= plan[idx] - 1'b1;
            count[idx] <= count[idx] - 1'b1;
            RESTANTE   <= RESTANTE - denom_i;
            state      <= S_GAP;
          end else if (expired) begin
            ERROR_CODE <= ERR_TIMEOUT;
            state      <= S_FAIL;
          end
        S_GAP: state <= S_DISPENSE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cash_dispenser_sequencer.sv
// tb_cash_dispenser_sequencer: directed and random transactions against a greedy-breakdown model
module tb_cash_dispenser_sequencer;
  logic        CLK = 0;
  logic        RESET = 0;
  logic        ENTREGAR_DINERO = 0;
  logic [31:0] MONTO = 0;
  logic        RECARGA = 0;
  logic        BILLETE_ACK = 0;
  logic        BILLETE_STB;
  logic [1:0]  BILLETE_SEL;
  logic        OCUPADO, ENTREGA_OK, ENTREGA_ERROR;
  logic [1:0]  ERROR_CODE;
  logic [31:0] RESTANTE;

  int checks = 0;
  int errors = 0;
  int cnt_m [4];
  int den [4] = '{20000, 10000, 5000, 1000};

  cash_dispenser_sequencer dut (
    .CLK(CLK), .RESET(RESET), .ENTREGAR_DINERO(ENTREGAR_DINERO), .MONTO(MONTO),
    .RECARGA(RECARGA), .BILLETE_ACK(BILLETE_ACK), .BILLETE_STB(BILLETE_STB),
    .BILLETE_SEL(BILLETE_SEL), .OCUPADO(OCUPADO), .ENTREGA_OK(ENTREGA_OK),
    .ENTREGA_ERROR(ENTREGA_ERROR), .ERROR_CODE(ERROR_CODE), .RESTANTE(RESTANTE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < 4; k++) check(tag, dut.count[k], cnt_m[k]);
  endtask

  task automatic reload();
    @(negedge CLK);
    RECARGA = 1;
    @(negedge CLK);
    RECARGA = 0;
    for (int k = 0; k < 4; k++) cnt_m[k] = 50;
  endtask

  // delay: STB-high cycle on which ACK is driven (0 = never); abort_bill: bill index at which reset hits
  task automatic run_txn(input int amt, input int delay, input int abort_bill,
                         input bit noise, input bit dup_start, input bit with_reload);
    int q[$];
    int r, n, pos, cyc, run, first, rest_m, exp_sel;
    bit pend, done, aborted, composable, tmo, exp_ok;
    if (with_reload) for (int k = 0; k < 4; k++) cnt_m[k] = 50;
    r = amt;
    for (int d = 0; d < 4; d++) begin
      n = r / den[d];
      if (n > cnt_m[d]) n = cnt_m[d];
      repeat (n) q.push_back(d);
      r -= n * den[d];
    end
    composable = r == 0;
    @(negedge CLK);
    ENTREGAR_DINERO = 1;
    MONTO = amt;
    RECARGA = with_reload;
    @(negedge CLK);
    ENTREGAR_DINERO = 0;
    RECARGA = 0;
    MONTO = $urandom;
    check("busy_rise", OCUPADO, 1);
    rest_m = amt;
    cyc = 0; pos = 0; run = 0; first = -1;
    pend = 0; done = 0; aborted = 0;
    while (!done && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      ENTREGAR_DINERO = 0;
      if (dup_start && cyc == 2) begin
        ENTREGAR_DINERO = 1;
        MONTO = amt + 1000;
      end
      if (pend) begin
        check("stb_gap", BILLETE_STB, 0);
        cnt_m[q[pos]]--;
        rest_m -= den[q[pos]];
        pos++;
        check("restante", RESTANTE, rest_m);
        pend = 0;
        run = 0;
      end
      if (ENTREGA_OK || ENTREGA_ERROR) begin
        done = 1;
        BILLETE_ACK = 0;
      end else if (BILLETE_STB) begin
        exp_sel = pos < q.size() ? q[pos] : 9;
        if (run == 0 && first < 0) first = cyc;
        check(run == 0 ? "sel" : "sel_stable", BILLETE_SEL, exp_sel);
        if (run == 0 && pos == abort_bill) begin
          RESET = 0;
          BILLETE_ACK = 0;
          #1;
          for (int k = 0; k < 4; k++) cnt_m[k] = 0;
          check("rst_stb", BILLETE_STB, 0);
          check("rst_busy", OCUPADO, 0);
          check("rst_ok", ENTREGA_OK, 0);
          check("rst_err", ENTREGA_ERROR, 0);
          check("rst_code", ERROR_CODE, 0);
          check("rst_rest", RESTANTE, 0);
          check_counts("rst_count");
          @(negedge CLK);
          check("rst_hold_ok", ENTREGA_OK | ENTREGA_ERROR, 0);
          RESET = 1;
          aborted = 1;
          done = 1;
        end else begin
          run++;
          BILLETE_ACK = delay != 0 && run == delay;
          pend = BILLETE_ACK;
        end
      end else begin
        BILLETE_ACK = noise && $urandom_range(3) == 0;
      end
    end
    BILLETE_ACK = 0;
    ENTREGAR_DINERO = 0;
    check("finished", done, 1);
    if (!aborted) begin
      tmo = composable && q.size() > 0 && delay == 0;
      exp_ok = composable && !tmo;
      check("ok", ENTREGA_OK, exp_ok);
      check("err", ENTREGA_ERROR, !exp_ok);
      check("busy_fall", OCUPADO, 0);
      check("code", ERROR_CODE, exp_ok ? 0 : (tmo ? 2 : 1));
      if (exp_ok) begin
        check("bills", pos, q.size());
        check("rest_zero", RESTANTE, 0);
      end
      if (!composable) check("no_stb", first, -1);
      if (tmo) check("timeout_len", run, 255);
      if (composable && q.size() > 0) check("first_stb", first, q.size() + 5 + q[0]);
      if (exp_ok && q.size() == 0) check("zero_lat", cyc >= 5 && cyc <= 7, 1);
      check_counts("count");
      @(negedge CLK);
      check("idle_after", OCUPADO | ENTREGA_OK | ENTREGA_ERROR, 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    repeat (3) @(negedge CLK);
    check("reset_stb", BILLETE_STB, 0);
    check("reset_busy", OCUPADO, 0);
    check("reset_pulses", ENTREGA_OK | ENTREGA_ERROR, 0);
    check("reset_code", ERROR_CODE, 0);
    check("reset_rest", RESTANTE, 0);
    check_counts("reset_count");
    RESET = 1;
    reload();
    check_counts("reload");
    run_txn(37000, 2, -1, 0, 0, 0);
    check("c0_49", dut.count[0], 49);
    check("c3_48", dut.count[3], 48);
    run_txn(37500, 2, -1, 0, 0, 0);
    reload();
    run_txn(1900000, 2, -1, 0, 0, 0);
`ifdef DISPENSER_TIMEOUT_EN
    reload();
    run_txn(20000, 0, -1, 0, 0, 0);
    check("tmo_c0", dut.count[0], 50);
`endif
    reload();
    run_txn(37000, 2, 1, 0, 0, 0);
    run_txn(37000, 2, -1, 0, 0, 0);
    reload();
    run_txn(0, 2, -1, 0, 1, 0);
    run_txn(58000, 1, -1, 1, 0, 1);
    for (int t = 0; t < 14; t++) begin
      int amt;
      amt = $urandom_range(0, 120) * 1000;
      if ($urandom_range(7) == 0) amt += $urandom_range(1, 999);
      run_txn(amt, $urandom_range(1, 4), -1, 1, $urandom_range(3) == 0, $urandom_range(3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
